i2c_reg_sequencer: RTL and testbench



---
 rtl/i2c_seq_pkg.sv | 61 ++++++
 rtl/i2c_reg_sequencer_if.sv | 48 ++++
 rtl/i2c_seq_watchdog.sv | 39 +++
 rtl/i2c_reg_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C register sequencer: FSM states, byte-list helpers
// and the latched request payload.
package i2c_seq_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned N_BYTES = 4;
    localparam int unsigned IDX_W   = 2;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND,
        READ,
        STOP,
        WAIT
    } state_e;

    typedef logic [IDX_W-1:0]                idx_t;
    typedef logic [BYTE_W-1:0]               byte_t;
    typedef logic [N_BYTES-1:0][BYTE_W-1:0]  byte_list_t;

    typedef struct packed {
        logic        rw;
        logic [6:0]  dev;
        logic [15:0] reg_addr;
        logic        wide;
        logic [1:0]  len;
        logic [15:0] wdata;
    } req_t;

    // A length of 3 behaves as 2.
    function automatic idx_t eff_len(input logic [1:0] len);
        return (len == 2'd3) ? idx_t'(2) : idx_t'(len);
    endfunction

    // Outgoing bytes in bus order: register address (MSB first), then write data.
    function automatic byte_list_t build_bytes(input req_t r);
        byte_list_t l;
        byte_t      d0;
        byte_t      d1;
        d0 = (eff_len(r.len) == idx_t'(2)) ? r.wdata[15:8] : r.wdata[7:0];
        d1 = r.wdata[7:0];
        if (r.wide) begin
            l = {d1, d0, r.reg_addr[7:0], r.reg_addr[15:8]};
        end else begin
            l = {8'h00, d1, d0, r.reg_addr[7:0]};
        end
        return l;
    endfunction

    // Index of the last byte driven on ctl_tx (reads send address bytes only).
    function automatic idx_t last_tx_idx(input req_t r);
        idx_t data_n;
        data_n = (r.rw == RW_WRITE) ? eff_len(r.len) : idx_t'(0);
        return idx_t'({1'b0, r.wide}) + data_n;
    endfunction

endpackage

// File: rtl/i2c_reg_sequencer_if.sv
// Request/response and controller-handshake signals of the register sequencer.
interface i2c_reg_sequencer_if;
    import i2c_seq_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [6:0]  req_dev_addr;
    logic [15:0] req_reg_addr;
    logic        req_reg_wide;
    logic [1:0]  req_len;
    logic [15:0] req_wdata;

    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_nack;
    logic        rsp_timeout;

    logic        ctl_start;
    logic        ctl_stop;
    logic        ctl_rwbit;
    logic [6:0]  ctl_periph_addr;
    logic [15:0] ctl_tx;
    logic [15:0] ctl_rx;
    logic        ctl_busy;
    logic        ctl_loading;
    logic        ctl_starting;
    logic        ctl_nack;

    // Sequencer side.
    modport slave (
        input  req_valid, req_rw, req_dev_addr, req_reg_addr, req_reg_wide, req_len, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_nack, rsp_timeout,
        output ctl_start, ctl_stop, ctl_rwbit, ctl_periph_addr, ctl_tx,
        input  ctl_rx, ctl_busy, ctl_loading, ctl_starting, ctl_nack
    );

    // Requester plus controller side.
    modport master (
        output req_valid, req_rw, req_dev_addr, req_reg_addr, req_reg_wide, req_len, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_nack, rsp_timeout,
        input  ctl_start, ctl_stop, ctl_rwbit, ctl_periph_addr, ctl_tx,
        output ctl_rx, ctl_busy, ctl_loading, ctl_starting, ctl_nack
    );

endinterface

// File: rtl/i2c_seq_watchdog.sv
// Inactivity counter: expires after TIMEOUT_CYCLES enabled cycles without a kick.
module i2c_seq_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned TW             = 21
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    input  logic kick_i,
    output logic expire_c_o
);

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Expiry is independent of clr_i so the caller may derive clr_i from the next state.
    assign expire_c_o = en_i && !kick_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || kick_i || !en_i) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Turns one register read/write request into the byte-level start/stop/txBuffer
// handshake of the I2C controller and returns data/status on a response strobe.
module i2c_reg_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned TW             = 21
) (
    input  logic                clk,
    input  logic                rst_n,
    i2c_reg_sequencer_if.slave  seq_if
);

    state_e      state_q, state_d;
    req_t        req_c;
    logic        accept_c, last_tx_c, last_rd_c;
    logic        wd_en_c, wd_clr_c, wd_kick_c, wd_expire_c;
    logic        rx_hi_unused_c;

    logic        req_ready_q, req_ready_d;
    logic        ctl_start_q, ctl_start_d;
    logic        ctl_stop_q, ctl_stop_d;
    logic        ctl_rwbit_q, ctl_rwbit_d;
    logic [6:0]  periph_q, periph_d;
    logic [15:0] ctl_tx_q, ctl_tx_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_nack_q, rsp_nack_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;

    byte_list_t  bytes_q, bytes_d;
    idx_t        idx_q, idx_d;
    idx_t        last_tx_q, last_tx_d;
    idx_t        rd_last_q, rd_last_d;
    logic        rw_q, rw_d;
    logic [15:0] acc_q, acc_d;
    logic        nack_seen_q, nack_seen_d;
    logic        to_seen_q, to_seen_d;

    assign req_c = '{
        rw:       seq_if.req_rw,
        dev:      seq_if.req_dev_addr,
        reg_addr: seq_if.req_reg_addr,
        wide:     seq_if.req_reg_wide,
        len:      seq_if.req_len,
        wdata:    seq_if.req_wdata
    };

    // Only the low byte of rxBuffer carries data.
    assign rx_hi_unused_c = ^seq_if.ctl_rx[15:8];

    assign accept_c  = (state_q == IDLE) && seq_if.req_valid && req_ready_q;
    assign last_tx_c = (idx_q == last_tx_q);
    assign last_rd_c = (idx_q == rd_last_q);

    assign wd_en_c   = (state_q != IDLE) && (state_q != WAIT);
    assign wd_kick_c = seq_if.ctl_loading || seq_if.ctl_starting;
    assign wd_clr_c  = (state_d != state_q);

    i2c_seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TW             (TW)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (wd_en_c),
        .clr_i      (wd_clr_c),
        .kick_i     (wd_kick_c),
        .expire_c_o (wd_expire_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; NACK and watchdog expiry pre-empt byte progress.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept_c) state_d = START;
            end
            START, SEND: begin
                if (seq_if.ctl_nack || wd_expire_c) begin
                    state_d = STOP;
                end else if (seq_if.ctl_loading && last_tx_c) begin
                    state_d = (rw_q == RW_READ) ? READ : STOP;
                end else if (seq_if.ctl_loading || seq_if.ctl_starting) begin
                    state_d = SEND;
                end
            end
            READ: begin
                if (seq_if.ctl_nack || wd_expire_c) begin
                    state_d = STOP;
                end else if (seq_if.ctl_loading && last_rd_c) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (!seq_if.ctl_busy || wd_expire_c) state_d = WAIT;
            end
            WAIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs and datapath, decoded from the upcoming state.
    always_comb begin
        req_ready_d   = (state_d == IDLE);
        ctl_start_d   = (state_d == START) || (state_d == SEND) || (state_d == READ);
        ctl_stop_d    = (state_d == STOP);
        ctl_rwbit_d   = (state_d == READ);
        rsp_valid_d   = (state_d == WAIT);
        periph_d      = periph_q;
        ctl_tx_d      = ctl_tx_q;
        rsp_nack_d    = rsp_nack_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_rdata_d   = rsp_rdata_q;
        bytes_d       = bytes_q;
        idx_d         = idx_q;
        last_tx_d     = last_tx_q;
        rd_last_d     = rd_last_q;
        rw_d          = rw_q;
        acc_d         = acc_q;
        nack_seen_d   = nack_seen_q;
        to_seen_d     = to_seen_q;

        if (accept_c) begin
            bytes_d     = build_bytes(req_c);
            periph_d    = req_c.dev;
            rw_d        = req_c.rw;
            last_tx_d   = last_tx_idx(req_c);
            rd_last_d   = (eff_len(req_c.len) == idx_t'(2)) ? idx_t'(1) : idx_t'(0);
            idx_d       = '0;
            ctl_tx_d    = {8'h00, bytes_d[0]};
            acc_d       = '0;
            nack_seen_d = 1'b0;
            to_seen_d   = 1'b0;
        end

        // Byte consumed by the controller: present the next one.
        if ((state_q == START || state_q == SEND) && (state_d == SEND)
                && seq_if.ctl_loading && !last_tx_c) begin
            idx_d    = idx_q + idx_t'(1);
            ctl_tx_d = {8'h00, bytes_q[idx_q + idx_t'(1)]};
        end

        if (state_d == READ && state_q != READ) begin
            idx_d = '0;
        end

        if (state_q == READ && seq_if.ctl_loading) begin
            if (rd_last_q != idx_t'(0) && idx_q == idx_t'(0)) begin
                acc_d[15:8] = seq_if.ctl_rx[7:0];
            end else begin
                acc_d[7:0] = seq_if.ctl_rx[7:0];
            end
            idx_d = idx_q + idx_t'(1);
        end

        if (wd_en_c && seq_if.ctl_nack) nack_seen_d = 1'b1;
        if (wd_expire_c)                to_seen_d   = 1'b1;

        if (state_d == WAIT && state_q != WAIT) begin
            rsp_nack_d    = nack_seen_d;
            rsp_timeout_d = to_seen_d;
            rsp_rdata_d   = nack_seen_d ? 16'h0000 : acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready_q   <= 1'b0;
            ctl_start_q   <= 1'b0;
            ctl_stop_q    <= 1'b0;
            ctl_rwbit_q   <= 1'b0;
            periph_q      <= '0;
            ctl_tx_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_nack_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            bytes_q       <= '0;
            idx_q         <= '0;
            last_tx_q     <= '0;
            rd_last_q     <= '0;
            rw_q          <= RW_WRITE;
            acc_q         <= '0;
            nack_seen_q   <= 1'b0;
            to_seen_q     <= 1'b0;
        end else begin
            req_ready_q   <= req_ready_d;
            ctl_start_q   <= ctl_start_d;
            ctl_stop_q    <= ctl_stop_d;
            ctl_rwbit_q   <= ctl_rwbit_d;
            periph_q      <= periph_d;
            ctl_tx_q      <= ctl_tx_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_nack_q    <= rsp_nack_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
            bytes_q       <= bytes_d;
            idx_q         <= idx_d;
            last_tx_q     <= last_tx_d;
            rd_last_q     <= rd_last_d;
            rw_q          <= rw_d;
            acc_q         <= acc_d;
            nack_seen_q   <= nack_seen_d;
            to_seen_q     <= to_seen_d;
        end
    end

    assign seq_if.req_ready       = req_ready_q;
    assign seq_if.ctl_start       = ctl_start_q;
    assign seq_if.ctl_stop        = ctl_stop_q;
    assign seq_if.ctl_rwbit       = ctl_rwbit_q;
    assign seq_if.ctl_periph_addr = periph_q;
    assign seq_if.ctl_tx          = ctl_tx_q;
    assign seq_if.rsp_valid       = rsp_valid_q;
    assign seq_if.rsp_nack        = rsp_nack_q;
    assign seq_if.rsp_timeout     = rsp_timeout_q;
    assign seq_if.rsp_rdata       = rsp_rdata_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer; the bench plays both requester and controller.
module tb_i2c_reg_sequencer;

    localparam int unsigned TO = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rsp_seen = 0;
    logic [7:0] wr_bytes [4] = '{8'hCE, 8'h11, 8'hDE, 8'hAD};

    always #5 clk = ~clk;

    i2c_reg_sequencer_if bus ();

    i2c_reg_sequencer #(
        .TIMEOUT_CYCLES (TO),
        .TW             (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .seq_if (bus)
    );

    always @(negedge clk) if (bus.rsp_valid) rsp_seen++;

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "tb stuck");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input logic rw, input logic [6:0] dev, input logic [15:0] ra,
                           input logic wide, input logic [1:0] len, input logic [15:0] wd);
        bus.req_rw       = rw;
        bus.req_dev_addr = dev;
        bus.req_reg_addr = ra;
        bus.req_reg_wide = wide;
        bus.req_len      = len;
        bus.req_wdata    = wd;
    endtask

    task automatic send_req(input logic rw, input logic [6:0] dev, input logic [15:0] ra,
                            input logic wide, input logic [1:0] len, input logic [15:0] wd);
        set_req(rw, dev, ra, wide, len, wd);
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic pulse_starting();
        bus.ctl_starting = 1'b1;
        tick();
        bus.ctl_starting = 1'b0;
    endtask

    task automatic pulse_loading(input logic [7:0] rx);
        bus.ctl_rx      = {8'h00, rx};
        bus.ctl_loading = 1'b1;
        tick();
        bus.ctl_loading = 1'b0;
    endtask

    // Controller drops busy while in STOP; expect the response next cycle.
    task automatic finish_txn(input string tag, input logic exp_nack, input logic chk_data,
                              input logic [15:0] exp_data);
        bus.ctl_busy = 1'b0;
        tick();
        check_eq({tag, "_rsp_valid"}, bus.rsp_valid, 1);
        check_eq({tag, "_rsp_nack"}, bus.rsp_nack, exp_nack);
        check_eq({tag, "_rsp_timeout"}, bus.rsp_timeout, 0);
        if (chk_data) check_eq({tag, "_rsp_rdata"}, bus.rsp_rdata, exp_data);
        tick();
        check_eq({tag, "_rsp_pulse"}, bus.rsp_valid, 0);
        check_eq({tag, "_ready_back"}, bus.req_ready, 1);
    endtask

    initial begin
        int k;
        bus.req_valid = 0; bus.ctl_rx = '0; bus.ctl_busy = 0;
        bus.ctl_loading = 0; bus.ctl_starting = 0; bus.ctl_nack = 0;
        set_req(0, 7'h00, 16'h0000, 0, 2'd0, 16'h0000);

        repeat (3) tick();
        check_eq("rst_ready", bus.req_ready, 0);
        check_eq("rst_start", bus.ctl_start, 0);
        check_eq("rst_tx", bus.ctl_tx, 0);
        rst_n = 1'b1;
        tick();
        check_eq("rel_ready", bus.req_ready, 1);

        // Wide 16-bit-address write of two data bytes.
        send_req(0, 7'h13, 16'hCE11, 1, 2'd2, 16'hDEAD);
        check_eq("wr_start", bus.ctl_start, 1);
        check_eq("wr_ready_low", bus.req_ready, 0);
        check_eq("wr_dev", bus.ctl_periph_addr, 7'h13);
        bus.ctl_busy = 1'b1;
        pulse_starting();
        for (int i = 0; i < 4; i++) begin
            check_eq("wr_tx", bus.ctl_tx, {8'h00, wr_bytes[i]});
            check_eq("wr_rwbit", bus.ctl_rwbit, 0);
            pulse_loading(8'h00);
        end
        check_eq("wr_stop", bus.ctl_stop, 1);
        check_eq("wr_start_low", bus.ctl_start, 0);
        finish_txn("wr", 0, 0, 16'h0000);

        // Narrow-address read of two bytes.
        send_req(1, 7'h13, 16'h0042, 0, 2'd2, 16'h0000);
        bus.ctl_busy = 1'b1;
        pulse_starting();
        check_eq("rd_tx", bus.ctl_tx, 16'h0042);
        check_eq("rd_rwbit_pre", bus.ctl_rwbit, 0);
        pulse_loading(8'h00);
        check_eq("rd_rwbit", bus.ctl_rwbit, 1);
        check_eq("rd_start_held", bus.ctl_start, 1);
        pulse_starting();
        pulse_loading(8'hBE);
        check_eq("rd_mid_stop", bus.ctl_stop, 0);
        pulse_loading(8'hEF);
        check_eq("rd_stop", bus.ctl_stop, 1);
        finish_txn("rd", 0, 1, 16'hBEEF);

        // NACK after the first address byte.
        send_req(0, 7'h22, 16'h1234, 1, 2'd1, 16'h0055);
        bus.ctl_busy = 1'b1;
        pulse_starting();
        pulse_loading(8'h00);
        check_eq("nk_tx1", bus.ctl_tx, 16'h0034);
        bus.ctl_nack = 1'b1;
        tick();
        bus.ctl_nack = 1'b0;
        check_eq("nk_stop", bus.ctl_stop, 1);
        check_eq("nk_start_low", bus.ctl_start, 0);
        repeat (3) tick();
        check_eq("nk_tx_hold", bus.ctl_tx, 16'h0034);
        finish_txn("nk", 1, 1, 16'h0000);

        // Controller stalls: watchdog forces STOP, then WAIT with busy stuck high.
        send_req(0, 7'h31, 16'h0099, 0, 2'd0, 16'h0000);
        check_eq("to_start", bus.ctl_start, 1);
        bus.ctl_busy = 1'b1;
        k = 0;
        while (!bus.ctl_stop && k < 300) begin
            tick();
            k++;
        end
        check_eq("to_stop_cycle", k, TO);
        k = 0;
        while (!bus.rsp_valid && k < 300) begin
            tick();
            k++;
        end
        check_eq("to_wait_cycle", k, TO);
        check_eq("to_rsp_timeout", bus.rsp_timeout, 1);
        check_eq("to_rsp_nack", bus.rsp_nack, 0);
        check_eq("to_stop_low", bus.ctl_stop, 0);
        bus.ctl_busy = 1'b0;
        tick();
        check_eq("to_ready_back", bus.req_ready, 1);

        // Back-to-back: pointer-set write, read request already waiting.
        send_req(0, 7'h13, 16'h0010, 0, 2'd0, 16'h0000);
        set_req(1, 7'h13, 16'h0007, 0, 2'd1, 16'h0000);
        bus.req_valid = 1'b1;
        bus.ctl_busy  = 1'b1;
        pulse_starting();
        check_eq("bb_ready_low", bus.req_ready, 0);
        check_eq("bb_tx", bus.ctl_tx, 16'h0010);
        pulse_loading(8'h00);
        check_eq("bb_wr_stop", bus.ctl_stop, 1);
        bus.ctl_busy = 1'b0;
        tick();
        check_eq("bb_wr_rsp", bus.rsp_valid, 1);
        check_eq("bb_wr_nack", bus.rsp_nack, 0);
        check_eq("bb_no_start", bus.ctl_start, 0);
        tick();
        check_eq("bb_gap_start", bus.ctl_start, 0);
        check_eq("bb_gap_ready", bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        check_eq("bb_rd_start", bus.ctl_start, 1);
        bus.ctl_busy = 1'b1;
        pulse_starting();
        pulse_loading(8'h00);
        pulse_starting();
        pulse_loading(8'h5A);
        check_eq("bb_rd_stop", bus.ctl_stop, 1);
        finish_txn("bb_rd", 0, 1, 16'h005A);

        // Reset mid-SEND, then a fresh write with length 3 (sent as 2).
        send_req(0, 7'h44, 16'hA0B1, 1, 2'd2, 16'hCAFE);
        bus.ctl_busy = 1'b1;
        pulse_starting();
        pulse_loading(8'h00);
        rst_n = 1'b0;
        bus.ctl_busy = 1'b0;
        tick();
        check_eq("mr_start", bus.ctl_start, 0);
        check_eq("mr_stop", bus.ctl_stop, 0);
        check_eq("mr_ready", bus.req_ready, 0);
        check_eq("mr_tx", bus.ctl_tx, 0);
        check_eq("mr_dev", bus.ctl_periph_addr, 0);
        check_eq("mr_rdata", bus.rsp_rdata, 0);
        rst_n = 1'b1;
        tick();
        check_eq("mr_ready_back", bus.req_ready, 1);
        send_req(0, 7'h45, 16'h0021, 0, 2'd3, 16'h1234);
        bus.ctl_busy = 1'b1;
        pulse_starting();
        check_eq("fw_tx0", bus.ctl_tx, 16'h0021);
        pulse_loading(8'h00);
        check_eq("fw_tx1", bus.ctl_tx, 16'h0012);
        pulse_loading(8'h00);
        check_eq("fw_tx2", bus.ctl_tx, 16'h0034);
        check_eq("fw_mid_stop", bus.ctl_stop, 0);
        pulse_loading(8'h00);
        check_eq("fw_stop", bus.ctl_stop, 1);
        finish_txn("fw", 0, 0, 16'h0000);

        check_eq("rsp_count", rsp_seen, 7);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
